// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt pending controller.
package irq_pkg;

  localparam int NUM_CH = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } irq_state_e;

endpackage

// File: rtl/irq_edge_sync.sv
// Per-channel rising-edge detector for the raw request lines.
// Build option IRQ_SYNC_EN: insert a 2-flop synchroniser in front of the
// edge detector for request lines that are asynchronous to clk.
module irq_edge_sync
  import irq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] req_edge
);

  logic [NUM_CH-1:0] req_s;
  logic [NUM_CH-1:0] req_q;

`ifdef IRQ_SYNC_EN
  logic [NUM_CH-1:0] sync_q1;
  logic [NUM_CH-1:0] sync_q2;

  // Two-stage synchroniser, one pair of flops per channel.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= req;
      sync_q2 <= sync_q1;
    end
  end

  assign req_s = sync_q2;
`else
  // Requests are already synchronous to clk.
  assign req_s = req;
`endif

  // Previous-cycle copy of the request lines for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req_s;
    end
  end

  // A held-high line yields a single-cycle edge pulse only.
  assign req_edge = req_s & ~req_q;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Request capture and service stage around an external 4:2 priority encoder.
// Captures request edges into sticky pending bits, drives the masked pending
// vector to the encoder, presents the encoder's winner over valid/ack and
// counts edges lost because their channel was already pending.
// Build option IRQ_SYNC_EN: synchronise req_i before edge detection.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] mask_i,
  output logic [NUM_CH-1:0] pend_o,
  input  logic              enc_a_i,
  input  logic              enc_b_i,
  input  logic              enc_v_i,
  output logic              irq_valid_o,
  output logic [CODE_W-1:0] irq_code_o,
  input  logic              irq_ack_i,
  output logic [CNT_W-1:0]  lost_cnt_o,
  input  logic              lost_clr_i
);

  localparam int SUM_W = CNT_W + 1;

  irq_state_e        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              ack_fire;
  logic [NUM_CH-1:0] req_edge;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] clr_vec;
  logic [NUM_CH-1:0] lost_vec;
  logic [CNT_W-1:0]  lost_q, lost_d;
  logic [SUM_W-1:0]  lost_sum;

  irq_edge_sync u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_i),
    .req_edge (req_edge)
  );

  // Presentation FSM: latch the encoder's winner in IDLE, hold it until acked.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    ack_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_v_i) begin
          code_d  = {enc_a_i, enc_b_i};
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (irq_ack_i) begin
          ack_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and presented code registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // Pending update: clear on ack of the presented channel, then a new edge
  // re-sets it, so a re-request coincident with its own ack survives.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      clr_vec[i] = ack_fire && (code_q == CODE_W'(i));
    end
    pending_d = (pending_q & ~clr_vec) | req_edge;
    lost_vec  = req_edge & pending_q & ~clr_vec;
  end

  // Sticky pending bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Lost-edge counter: add one per losing channel with a carry bit, then clamp.
  always_comb begin
    lost_sum = {1'b0, lost_q};
    for (int i = 0; i < NUM_CH; i++) begin
      if (lost_vec[i]) begin
        lost_sum = lost_sum + SUM_W'(1);
      end
    end
    if (lost_clr_i) begin
      lost_d = '0;
    end else if (lost_sum[CNT_W]) begin
      lost_d = '1;
    end else begin
      lost_d = lost_sum[CNT_W-1:0];
    end
  end

  // Lost-edge counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_q <= '0;
    end else begin
      lost_q <= lost_d;
    end
  end

  assign pend_o      = pending_q & ~mask_i;
  assign irq_valid_o = (state_q == BUSY);
  assign irq_code_o  = code_q;
  assign lost_cnt_o  = lost_q;

endmodule
